regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
Shares the single write port and single registered read port of the parameterized register file among NREQ requesters.
- One transaction per cycle, round-robin fairness.
- Routes 1-cycle-latency read data back to the requester that issued the read.
- Includes a CLEAR sequencer that walks every address writing zero, for software-visible re-initialisation without a global reset.

Parameters:
NREQ, 2, number of requesters (>=2)
DEPTH, 8, register count; must match the register file DEPTH
WIDTH, 8, register width; must match the register file WIDTH
(AW = $clog2(DEPTH), derived)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
init_start  input  1  pulse: start CLEAR walk (honoured only in IDLE)
init_busy  output  1  high while in CLEAR
init_done  output  1  one-cycle pulse on the last CLEAR write cycle
req_valid  input  NREQ  per-requester request
req_we  input  NREQ  1 = write, 0 = read
req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  input  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot grant; transfer when valid & ready
resp_valid  output  NREQ  one-hot read response, registered
resp_data  output  WIDTH  read data; valid only with resp_valid
rf_enable  output  1  register file enable
rf_write_en  output  1  register file write enable
rf_write_addr  output  AW  register file write address
rf_write_data  output  WIDTH  register file write data
rf_read_addr  output  AW  register file read address
rf_read_data  input  WIDTH  register file registered read output

Behaviour:
- States: IDLE, CLEAR. Reset -> IDLE, clear counter = 0, rr pointer = 0, resp_valid = 0, init_busy = 0, init_done = 0.
- IDLE arbitration:
  - Grant the first valid requester searching from index ptr upward, wrapping modulo NREQ.
  - req_ready is combinational from req_valid and ptr; at most one bit is set.
  - After a grant to k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
  - Requesters hold valid, we, addr and wdata stable until ready.
- Granted write: rf_write_en = rf_enable = 1, rf_write_addr/data = requester fields. The register updates at the same edge.
- Granted read: rf_read_addr = requester addr; resp_valid[k] <= 1 at that edge.
  - In the next cycle, resp_valid[k] = 1 and resp_data = rf_read_data (passthrough). Latency = 1 cycle.
  - Back-to-back reads produce back-to-back responses.
- Outputs when not granting:
  - rf_write_en = rf_enable = 0.
  - rf_read_addr = 0 and its response is discarded; resp_valid = 0 next cycle.
- Read-after-write: a write granted in cycle N, followed by a read of the same address in cycle N+1, returns the new data in N+2.
- Entering CLEAR: init_start in IDLE -> CLEAR at the next edge. Arbitration in the init_start cycle proceeds normally.
- In CLEAR:
  - req_ready = 0.
  - rf_write_en = rf_enable = 1, rf_write_addr = counter, rf_write_data = 0.
  - counter increments each cycle.
  - When counter == DEPTH-1: init_done = 1 for that cycle, then -> IDLE with counter = 0. CLEAR lasts exactly DEPTH cycles.
- A read response pending from the last IDLE cycle is still delivered in the first CLEAR cycle.
- init_start while in CLEAR is ignored; no restart.
- rst during CLEAR -> IDLE next edge, init_done not pulsed, pending resp_valid dropped.

Test Plan:
- After reset, req0 writes addr 3 = 0xA5; the next cycle req1 reads addr 3 -> req_ready pulses one-hot each cycle; resp_valid = 2'b10 and resp_data = 0xA5 one cycle after the read grant.
- Both requesters hold valid reads (req0 addr 1, req1 addr 2) for 4 cycles -> grants alternate 0,1,0,1; responses alternate with 1-cycle latency.
- Only req1 is valid for 3 cycles, then both are valid -> req1 is granted 3 times, then req0 is granted first (ptr wrapped to 0).
- Fill all 8 addresses with 0x11..0x88, pulse init_start -> init_busy high for exactly 8 cycles, no req_ready during it, init_done in the 8th cycle; subsequent reads of every address return 0x00.
- Assert rst in the 4th CLEAR cycle -> next cycle IDLE, init_busy = 0, no init_done; addresses 0-2 read 0, address 5 reads the register file's reset value.
- Read granted in the same cycle as init_start -> response delivered in the first CLEAR cycle with the pre-clear data.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Bus between NREQ requesters, the arbiter and a single-write/single-read
// register file. "master" is the requester/register-file side, "slave" is
// the arbiter.
interface regfile_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  init_start;
  logic                  init_busy;
  logic                  init_done;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic                  rf_enable;
  logic                  rf_write_en;
  logic [AW-1:0]         rf_write_addr;
  logic [WIDTH-1:0]      rf_write_data;
  logic [AW-1:0]         rf_read_addr;
  logic [WIDTH-1:0]      rf_read_data;

  modport master (
    output init_start, req_valid, req_we, req_addr, req_wdata, rf_read_data,
    input  init_busy, init_done, req_ready, resp_valid, resp_data,
           rf_enable, rf_write_en, rf_write_addr, rf_write_data, rf_read_addr
  );

  modport slave (
    input  init_start, req_valid, req_we, req_addr, req_wdata, rf_read_data,
    output init_busy, init_done, req_ready, resp_valid, resp_data,
           rf_enable, rf_write_en, rf_write_addr, rf_write_data, rf_read_addr
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file write port and one
// registered read port among NREQ requesters, with a CLEAR sequencer that
// writes zero to every address without needing a global reset.
module regfile_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  regfile_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [AW-1:0]   counter;
  logic [NREQ-1:0] resp_valid_q;

  logic            found;
  logic            take;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] grant_vec;
  logic            sel_we;
  logic            last_clear;

  // Search from ptr upward (wrapping) for the first valid requester.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  assign take       = found && (state == IDLE);
  assign ptr_next   = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
  assign grant_vec  = take ? (NREQ'(1) << grant_idx) : '0;
  assign sel_we     = bus.req_we[grant_idx];
  assign last_clear = (state == CLEAR) && (counter == AW'(DEPTH - 1));

  assign bus.req_ready  = grant_vec;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = bus.rf_read_data;
  assign bus.init_busy  = (state == CLEAR);
  assign bus.init_done  = last_clear;

  // Drive the register-file port from either the CLEAR walk or the granted requester.
  always_comb begin
    bus.rf_enable     = 1'b0;
    bus.rf_write_en   = 1'b0;
    bus.rf_write_addr = '0;
    bus.rf_write_data = '0;
    bus.rf_read_addr  = '0;
    if (state == CLEAR) begin
      bus.rf_enable     = 1'b1;
      bus.rf_write_en   = 1'b1;
      bus.rf_write_addr = counter;
    end else if (take) begin
      bus.rf_enable = 1'b1;
      if (sel_we) begin
        bus.rf_write_en   = 1'b1;
        bus.rf_write_addr = bus.req_addr[grant_idx*AW +: AW];
        bus.rf_write_data = bus.req_wdata[grant_idx*WIDTH +: WIDTH];
      end else begin
        bus.rf_read_addr = bus.req_addr[grant_idx*AW +: AW];
      end
    end
  end

  // State machine, round-robin pointer, clear counter and read-response tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      counter      <= '0;
      resp_valid_q <= '0;
    end else begin
      resp_valid_q <= (take && !sel_we) ? grant_vec : '0;
      case (state)
        IDLE: begin
          if (take) begin
            ptr <= ptr_next;
          end
          if (bus.init_start) begin
            state   <= CLEAR;
            counter <= '0;
          end
        end
        CLEAR: begin
          if (last_clear) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter with a behavioural
// register file (registered read, reset to zero by rst).
module tb_regfile_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_arbiter_if #(.NREQ(2), .DEPTH(8), .WIDTH(8)) bus ();

  regfile_arbiter #(.NREQ(2), .DEPTH(8), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: write on enable, read data registered every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      bus.rf_read_data <= '0;
    end else begin
      if (bus.rf_enable && bus.rf_write_en) mem[bus.rf_write_addr] <= bus.rf_write_data;
      bus.rf_read_data <= mem[bus.rf_read_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] we,
                                input logic [2:0] a0, input logic [2:0] a1,
                                input logic [7:0] d0, input logic [7:0] d1);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    #1;
  endtask

  task automatic write0(input logic [2:0] addr, input logic [7:0] data);
    apply_stimulus(2'b01, 2'b01, addr, 3'd0, data, 8'h00);
    check("wr_ready", 32'(bus.req_ready), 32'h1);
    check("wr_en", 32'(bus.rf_write_en), 32'h1);
    check("wr_addr", 32'(bus.rf_write_addr), 32'(addr));
    check("wr_data", 32'(bus.rf_write_data), 32'(data));
    tick();
    bus.req_valid = '0;
  endtask

  task automatic read0(input logic [2:0] addr, input logic [7:0] exp);
    apply_stimulus(2'b01, 2'b00, addr, 3'd0, 8'h00, 8'h00);
    check("rd_ready", 32'(bus.req_ready), 32'h1);
    check("rd_addr", 32'(bus.rf_read_addr), 32'(addr));
    tick();
    bus.req_valid = '0;
    check("rd_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("rd_resp_data", 32'(bus.resp_data), 32'(exp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.init_start = 1'b0;
    apply_stimulus(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    tick();
    tick();
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_busy", 32'(bus.init_busy), 32'h0);
    check("rst_done", 32'(bus.init_done), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rf_en", 32'(bus.rf_enable), 32'h0);
    rst = 1'b0;

    // Write via req0 then read-after-write via req1
    write0(3'd3, 8'hA5);
    apply_stimulus(2'b10, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00);
    check("raw_ready", 32'(bus.req_ready), 32'h2);
    check("raw_rd_addr", 32'(bus.rf_read_addr), 32'h3);
    check("raw_we", 32'(bus.rf_write_en), 32'h0);
    tick();
    bus.req_valid = '0;
    check("raw_resp_valid", 32'(bus.resp_valid), 32'h2);
    check("raw_resp_data", 32'(bus.resp_data), 32'hA5);

    // Seed addr1/addr2, then both requesters read continuously
    write0(3'd1, 8'h31);
    apply_stimulus(2'b10, 2'b10, 3'd0, 3'd2, 8'h00, 8'h32);
    check("w1_ready", 32'(bus.req_ready), 32'h2);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
      check("alt_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("alt_resp_valid", 32'(bus.resp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("alt_resp_data", 32'(bus.resp_data), (i % 2 == 0) ? 32'h31 : 32'h32);
    end
    apply_stimulus(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    check("idle_rf_en", 32'(bus.rf_enable), 32'h0);
    check("idle_rd_addr", 32'(bus.rf_read_addr), 32'h0);
    tick();
    check("idle_resp_valid", 32'(bus.resp_valid), 32'h0);

    // Only req1 for three cycles, then both: pointer wraps to req0
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(2'b10, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
      check("solo1_ready", 32'(bus.req_ready), 32'h2);
      tick();
    end
    apply_stimulus(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
    check("wrap_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    check("wrap_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;

    // Fill, then a full CLEAR walk
    for (int i = 0; i < 8; i++) write0(3'(i), 8'(8'h11 * (i + 1)));
    bus.init_start = 1'b1;
    apply_stimulus(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    check("pre_clear_busy", 32'(bus.init_busy), 32'h0);
    tick();
    bus.init_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(2'b11, 2'b11, 3'd4, 3'd5, 8'hFF, 8'hFF);
      check("clr_busy", 32'(bus.init_busy), 32'h1);
      check("clr_ready", 32'(bus.req_ready), 32'h0);
      check("clr_we", 32'(bus.rf_write_en), 32'h1);
      check("clr_addr", 32'(bus.rf_write_addr), 32'(i));
      check("clr_data", 32'(bus.rf_write_data), 32'h0);
      check("clr_done", 32'(bus.init_done), (i == 7) ? 32'h1 : 32'h0);
      tick();
    end
    bus.req_valid = '0;
    check("post_clr_busy", 32'(bus.init_busy), 32'h0);
    check("post_clr_done", 32'(bus.init_done), 32'h0);
    for (int i = 0; i < 8; i++) read0(3'(i), 8'h00);

    // Reset in the 4th CLEAR cycle
    for (int i = 0; i < 8; i++) write0(3'(i), 8'(8'h11 * (i + 1)));
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pclr_busy", 32'(bus.init_busy), 32'h1);
      tick();
    end
    rst = 1'b1;
    #1;
    check("rstclr_busy", 32'(bus.init_busy), 32'h1);
    check("rstclr_addr", 32'(bus.rf_write_addr), 32'h3);
    tick();
    rst = 1'b0;
    check("rstclr_idle", 32'(bus.init_busy), 32'h0);
    check("rstclr_done", 32'(bus.init_done), 32'h0);
    check("rstclr_resp", 32'(bus.resp_valid), 32'h0);
    read0(3'd0, 8'h00);
    read0(3'd1, 8'h00);
    read0(3'd2, 8'h00);
    read0(3'd5, 8'h00);

    // Read granted with init_start, CLEAR restart attempt ignored
    write0(3'd4, 8'h4C);
    bus.init_start = 1'b1;
    apply_stimulus(2'b10, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00);
    check("is_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.init_start = 1'b0;
    bus.req_valid  = '0;
    check("is_busy", 32'(bus.init_busy), 32'h1);
    check("is_resp_valid", 32'(bus.resp_valid), 32'h2);
    check("is_resp_data", 32'(bus.resp_data), 32'h4C);
    for (int i = 0; i < 8; i++) begin
      bus.init_start = (i == 2);
      #1;
      check("ig_busy", 32'(bus.init_busy), 32'h1);
      check("ig_done", 32'(bus.init_done), (i == 7) ? 32'h1 : 32'h0);
      tick();
    end
    bus.init_start = 1'b0;
    check("ig_end_busy", 32'(bus.init_busy), 32'h0);
    tick();
    check("ig_no_restart", 32'(bus.init_busy), 32'h0);
    read0(3'd4, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
